alu_ctrl_muldiv: RTL and testbench

Parametrised successor to the single-cycle ALU control decoder. It decodes aluOp/func into the registered 4-bit ALU control word and adds an iterative multiply/divide engine with architectural HI/LO registers. A busy/done handshake lets the MIPS datapath stall while the engine runs. The block sits between the main control unit and the ALU/writeback mux.

---
 rtl/alu_ctrl_muldiv.sv | 197 +++++++++++++++++++
 tb/tb_alu_ctrl_muldiv.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_muldiv.sv
// ALU control decoder with iterative multiply/divide engine and HI/LO registers.
// Optional macro ALUCTRL_ILLEGAL_TRAP_EN: unknown func/aluOp forces aluCtrl=1111 and pulses illegalOp.
module alu_ctrl_muldiv #(
    parameter int unsigned WIDTH  = 32,
    parameter bit          DIV_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [1:0]       aluOp,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic [3:0]       aluCtrl,
    output logic [1:0]       hiloSel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             illegalOp
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] acc_hi, acc_hi_nxt, acc_lo, acc_lo_nxt, opnd, opnd_nxt;
    logic             is_div, is_div_nxt, sgn_a, sgn_a_nxt, sgn_b, sgn_b_nxt;
    logic [3:0]       alu_nxt;
    logic [1:0]       sel_nxt;
    logic             busy_nxt, done_nxt, ill_nxt;
    logic [WIDTH-1:0] hi_nxt, lo_nxt;

    logic             accept, bad, start, start_div, sgn_f;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   shifted, trial, sum;
    logic [2*WIDTH-1:0] prod;

    // Next-state, decode and datapath step
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        acc_hi_nxt = acc_hi;
        acc_lo_nxt = acc_lo;
        opnd_nxt   = opnd;
        is_div_nxt = is_div;
        sgn_a_nxt  = sgn_a;
        sgn_b_nxt  = sgn_b;
        alu_nxt    = aluCtrl;
        sel_nxt    = hiloSel;
        hi_nxt     = hi;
        lo_nxt     = lo;
        ill_nxt    = 1'b0;
        accept     = req && !busy;
        bad        = 1'b0;
        start      = 1'b0;
        start_div  = 1'b0;
        sgn_f      = ~func[0];
        mag_a      = (sgn_f && opA[WIDTH-1]) ? -opA : opA;
        mag_b      = (sgn_f && opB[WIDTH-1]) ? -opB : opB;
        shifted    = {acc_hi, acc_lo[WIDTH-1]};
        trial      = shifted - {1'b0, opnd};
        sum        = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        prod       = {acc_hi, acc_lo};

        case (state)
            CALC: begin
                if (is_div) begin
                    acc_hi_nxt = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                    acc_lo_nxt = {acc_lo[WIDTH-2:0], ~trial[WIDTH]};
                end else begin
                    {acc_hi_nxt, acc_lo_nxt} = {sum, acc_lo[WIDTH-1:1]};
                end
                cnt_nxt = cnt + CW'(1);
                if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
            end
            FIX: begin
                if (is_div) begin
                    lo_nxt = (sgn_a ^ sgn_b) ? -acc_lo : acc_lo;
                    hi_nxt = sgn_a ? -acc_hi : acc_hi;
                end else begin
                    if (sgn_a ^ sgn_b) prod = -prod;
                    {hi_nxt, lo_nxt} = prod;
                end
                state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (accept) begin
            sel_nxt = 2'b00;
            case (aluOp)
                2'b00: alu_nxt = 4'b0010;
                2'b01: alu_nxt = 4'b0110;
                2'b10: begin
                    case (func)
                        F_ADD:            alu_nxt = 4'b0010;
                        F_SUB:            alu_nxt = 4'b0110;
                        F_AND:            alu_nxt = 4'b0000;
                        F_OR:             alu_nxt = 4'b0001;
                        F_SLT:            alu_nxt = 4'b0111;
                        F_NOR:            alu_nxt = 4'b1100;
                        F_MFHI:           sel_nxt = 2'b01;
                        F_MFLO:           sel_nxt = 2'b10;
                        F_MULT, F_MULTU:  start = 1'b1;
                        F_DIV, F_DIVU: begin
                            if (DIV_EN) begin
                                start     = 1'b1;
                                start_div = 1'b1;
                            end else begin
                                bad = 1'b1;
                            end
                        end
                        default:          bad = 1'b1;
                    endcase
                end
                default: bad = 1'b1;
            endcase
`ifdef ALUCTRL_ILLEGAL_TRAP_EN
            if (bad) begin
                alu_nxt = 4'b1111;
                ill_nxt = 1'b1;
            end
`endif
            // Divide by zero bypasses the engine entirely
            if (start_div && opB == '0) begin
                hi_nxt    = opA;
                lo_nxt    = '1;
                state_nxt = DONE;
            end else if (start) begin
                state_nxt  = CALC;
                cnt_nxt    = '0;
                acc_hi_nxt = '0;
                acc_lo_nxt = mag_a;
                opnd_nxt   = mag_b;
                is_div_nxt = start_div;
                sgn_a_nxt  = sgn_f && opA[WIDTH-1];
                sgn_b_nxt  = sgn_f && opB[WIDTH-1];
            end
        end

        busy_nxt = (state_nxt == CALC) || (state_nxt == FIX);
        done_nxt = (state_nxt == DONE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            opnd      <= '0;
            is_div    <= 1'b0;
            sgn_a     <= 1'b0;
            sgn_b     <= 1'b0;
            aluCtrl   <= 4'b0010;
            hiloSel   <= 2'b00;
            busy      <= 1'b0;
            done      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            illegalOp <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            acc_hi    <= acc_hi_nxt;
            acc_lo    <= acc_lo_nxt;
            opnd      <= opnd_nxt;
            is_div    <= is_div_nxt;
            sgn_a     <= sgn_a_nxt;
            sgn_b     <= sgn_b_nxt;
            aluCtrl   <= alu_nxt;
            hiloSel   <= sel_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            hi        <= hi_nxt;
            lo        <= lo_nxt;
            illegalOp <= ill_nxt;
        end
    end
endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Self-checking bench for alu_ctrl_muldiv: directed literal checks plus randomized model comparison.
module tb_alu_ctrl_muldiv;
    localparam int unsigned W = 32;

    logic         clk = 1'b0, rst = 1'b1, req = 1'b0;
    logic [1:0]   aluOp = 2'b00;
    logic [5:0]   func = 6'b0;
    logic [W-1:0] opA = '0, opB = '0;
    logic [3:0]   aluCtrl;
    logic [1:0]   hiloSel;
    logic         busy, done, illegalOp;
    logic [W-1:0] hi, lo;

    alu_ctrl_muldiv #(.WIDTH(W), .DIV_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .req(req), .aluOp(aluOp), .func(func),
        .opA(opA), .opB(opB), .aluCtrl(aluCtrl), .hiloSel(hiloSel),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .illegalOp(illegalOp)
    );

    always #5 clk = ~clk;

    int errs = 0, checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: per accepted request, arithmetic result plus a cycle countdown
    logic [3:0]   m_alu;
    logic [1:0]   m_sel;
    logic         m_busy, m_done, m_ill, m_valid = 1'b0;
    logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
    int           m_rem;

    task automatic arith(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] rh, output logic [W-1:0] rl);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f)
            6'h18:   p = 64'(sa * sb);
            6'h19:   p = ua * ub;
            6'h1a: begin q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]}; end
            default: p = {32'(ua % ub), 32'(ua / ub)};
        endcase
        {rh, rl} = p;
    endtask

    always @(posedge clk) begin : model
        logic ok, bad;
        if (rst) begin
            m_alu = 4'b0010; m_sel = 2'b00; m_busy = 1'b0; m_done = 1'b0;
            m_ill = 1'b0; m_hi = '0; m_lo = '0; m_rem = 0;
        end else begin
            ok = req && !m_busy;
            bad = 1'b0;
            m_done = 1'b0;
            m_ill = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_busy = 1'b0; m_done = 1'b1; m_hi = p_hi; m_lo = p_lo;
                end
            end
            if (ok) begin
                m_sel = 2'b00;
                if (aluOp == 2'd0) m_alu = 4'b0010;
                else if (aluOp == 2'd1) m_alu = 4'b0110;
                else if (aluOp == 2'd3) bad = 1'b1;
                else begin
                    case (func)
                        6'h20: m_alu = 4'b0010;
                        6'h22: m_alu = 4'b0110;
                        6'h24: m_alu = 4'b0000;
                        6'h25: m_alu = 4'b0001;
                        6'h2a: m_alu = 4'b0111;
                        6'h27: m_alu = 4'b1100;
                        6'h10: m_sel = 2'b01;
                        6'h12: m_sel = 2'b10;
                        6'h18, 6'h19, 6'h1a, 6'h1b: begin
                            if (func[1] && opB == '0) begin
                                m_hi = opA; m_lo = '1; m_done = 1'b1;
                            end else begin
                                arith(func, opA, opB, p_hi, p_lo);
                                m_busy = 1'b1;
                                m_rem = W + 1;
                            end
                        end
                        default: bad = 1'b1;
                    endcase
                end
`ifdef ALUCTRL_ILLEGAL_TRAP_EN
                if (bad) begin m_alu = 4'b1111; m_ill = 1'b1; end
`endif
            end
        end
        m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("aluCtrl", 64'(aluCtrl), 64'(m_alu));
            chk("hiloSel", 64'(hiloSel), 64'(m_sel));
            chk("busy", 64'(busy), 64'(m_busy));
            chk("done", 64'(done), 64'(m_done));
            chk("hi", 64'(hi), 64'(m_hi));
            chk("lo", 64'(lo), 64'(m_lo));
            chk("illegalOp", 64'(illegalOp), 64'(m_ill));
        end
    end

    task automatic issue(input logic [1:0] op, input logic [5:0] f,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        aluOp = op; func = f; opA = a; opB = b; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    // Called in the cycle after acceptance; returns cycle index of done and busy cycles seen
    task automatic wait_done(output int cyc, output int bcnt);
        cyc = 1;
        bcnt = 0;
        while (!done && cyc < 200) begin
            if (busy) bcnt++;
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", 64'(done), 64'd1);
    endtask

    task automatic mdop(input string name, input logic [5:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el,
                        input int ecyc, input int ebusy);
        int cyc, bc;
        issue(2'b10, f, a, b);
        wait_done(cyc, bc);
        chk({name, "_cycles"}, 64'(cyc), 64'(ecyc));
        chk({name, "_busy_cycles"}, 64'(bc), 64'(ebusy));
        chk({name, "_hi"}, 64'(hi), 64'(eh));
        chk({name, "_lo"}, 64'(lo), 64'(el));
        @(negedge clk);
    endtask

    logic [5:0] flist [14] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27, 6'h10,
                               6'h12, 6'h18, 6'h19, 6'h1a, 6'h1b, 6'h3f, 6'h00};

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_aluCtrl", 64'(aluCtrl), 64'h2);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_hilo", 64'({hi, lo}), 64'h0);
        rst = 1'b0;
        @(negedge clk);

        issue(2'b00, 6'h00, '0, '0); chk("dec_add", 64'(aluCtrl), 64'h2);
        issue(2'b01, 6'h00, '0, '0); chk("dec_sub", 64'(aluCtrl), 64'h6);
        issue(2'b10, 6'h27, '0, '0); chk("dec_nor", 64'(aluCtrl), 64'hC);
        issue(2'b10, 6'h2a, '0, '0); chk("dec_slt", 64'(aluCtrl), 64'h7);

        mdop("mult", 6'h18, 32'hFFFF_FFFD, 32'h7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 34, 33);
        mdop("multu", 6'h19, 32'hFFFF_FFFD, 32'h7, 32'h6, 32'hFFFF_FFEB, 34, 33);
        mdop("divu", 6'h1b, 32'd100, 32'd7, 32'd2, 32'd14, 34, 33);
        mdop("div_neg", 6'h1a, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 33);
        mdop("div_ovf", 6'h1a, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 34, 33);
        mdop("div_zero", 6'h1a, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF, 1, 0);

        // Request during busy is dropped; reset aborts the engine
        issue(2'b01, 6'h00, '0, '0);
        issue(2'b10, 6'h18, 32'd5, 32'd9);
        repeat (3) @(negedge clk);
        issue(2'b10, 6'h20, '0, '0);
        chk("busy_ignore_alu", 64'(aluCtrl), 64'h6);
        chk("busy_ignore_busy", 64'(busy), 64'h1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_hilo", 64'({hi, lo}), 64'h0);
        chk("abort_busy", 64'(busy), 64'h0);
        chk("abort_done", 64'(done), 64'h0);
        repeat (40) @(negedge clk);
        issue(2'b10, 6'h10, '0, '0);
        chk("mfhi_sel", 64'(hiloSel), 64'h1);

        issue(2'b10, 6'h3f, '0, '0);
`ifdef ALUCTRL_ILLEGAL_TRAP_EN
        chk("illegal_alu", 64'(aluCtrl), 64'hF);
        chk("illegal_pulse", 64'(illegalOp), 64'h1);
`else
        chk("illegal_alu", 64'(aluCtrl), 64'h2);
        chk("illegal_pulse", 64'(illegalOp), 64'h0);
`endif
        @(negedge clk);
        chk("illegal_clear", 64'(illegalOp), 64'h0);

        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 299) == 0);
            req   = ($urandom_range(0, 2) != 0);
            aluOp = ($urandom_range(0, 3) != 0) ? 2'b10 : 2'($urandom_range(0, 3));
            func  = flist[$urandom_range(0, 13)];
            opA   = rnd_op();
            opB   = ($urandom_range(0, 7) == 0) ? '0 : rnd_op();
            @(negedge clk);
        end
        rst = 1'b0;
        req = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
